rv_int_ctrl: RTL and testbench
==============================

Name: rv_int_ctrl

Overview:
- Interrupt controller between the 16 external interrupt lines (int_i) and the RV32I core's interrupt input.
- Synchronizes the lines, detects edges or levels per source, latches pending bits and applies a mask.
- Selects the highest-priority request and presents it to the core over a req/ack handshake, with end-of-interrupt (EOI) tracking.
- Software reaches its registers through a simple single-cycle register port on the data bus.

Parameters:
- NUM_SRC, 16, number of interrupt sources (1..16); bits at and above NUM_SRC read 0 and never request.
- ID_W, 4, width of the interrupt id.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- int_i  in  16  raw external interrupt lines, asynchronous to clk
- we_i  in  1  register write strobe, one cycle per write
- addr_i  in  4  register byte address (0x0, 0x4, 0x8, 0xC)
- data_i  in  32  write data
- data_o  out  32  read data, combinational from addr_i
- irq_o  out  1  interrupt request to core
- irq_id_o  out  4  id of the requested source; valid while irq_o=1
- irq_ack_i  in  1  core accepts the request; one-cycle pulse

Behaviour:
- Reset (rst=0, async): MASK=0, EDGE=0, PEND=0, sync flops=0, FSM=IDLE, irq_o=0, irq_id_o=0, data_o follows the reset register values.
- Registers:
  - 0x0 MASK RW, 1 = enabled.
  - 0x4 EDGE RW, 1 = rising-edge source, 0 = level source.
  - 0x8 PEND R; a write clears the bits that are 1 in data_i (write-1-to-clear).
  - 0xC STAT R: {27'b0, busy, id[3:0]}. Any write to 0xC is EOI.
  - Bits 31:16 of MASK/EDGE/PEND read 0.
- Input path: two-flop synchronizer per line (s1, s2), then a prev flop. Edge = s2 & ~prev.
- Pending, edge source: set on edge; cleared by a W1C write or by irq_ack_i for that id. A set in the same cycle as a clear wins, so pend stays 1.
- Pending, level source: pend bit = s2 (not latched); W1C has no effect.
- req_vec = PEND & MASK. Priority: lowest index wins (bit 0 highest).
- FSM states: IDLE, REQ, BUSY.
  - IDLE: if req_vec != 0 at a clock edge, latch id = lowest set bit, set irq_o=1, go REQ.
  - REQ: irq_o and irq_id_o held stable.
    - irq_ack_i=1: clear PEND[id] if it is an edge source; irq_o=0; go BUSY.
    - req_vec[id]=0 (masked or cleared) without ack: irq_o=0; go IDLE, withdrawn.
    - Ack takes precedence over withdrawal in the same cycle.
  - BUSY: irq_o=0; no new request is issued (no nesting). A write to 0xC returns the FSM to IDLE. IDLE may re-request on the next edge.
- Ack in IDLE or BUSY is ignored. EOI written in IDLE or REQ is ignored.
- Latency: int_i rising and held, edge source unmasked, FSM IDLE: PEND set on the 3rd clk edge, irq_o=1 after the 4th.
- A higher-priority request arriving during REQ does not preempt; it is served after EOI.
- Reset asserted mid-operation returns everything to the reset values immediately. No acknowledgement is generated.

Optional Feature:
- Macro: RV_INT_CTRL_SYNC_EN.
  - Defined: two-flop synchronizer present; latency as above (irq_o after the 4th edge).
  - Undefined: s2 is replaced by int_i directly (inputs must already be synchronous to clk); PEND is set on the 1st edge and irq_o rises after the 2nd edge.
- Register map and FSM are identical in both builds.

Test Plan:
- Reset: hold rst=0 with int_i=16'hFFFF -> irq_o=0, data_o=0 at addresses 0x0/0x4/0x8/0xC; release -> still irq_o=0 (MASK=0).
- Edge path: MASK=16'h0010, EDGE=16'h0010, pulse int_i[4] for 1 cycle -> PEND=16'h0010, irq_o=1 with irq_id_o=4 after the 4th edge; ack -> PEND=0, STAT=0x14; write 0xC -> STAT busy=0.
- Priority: MASK=16'hFFFF, EDGE=16'hFFFF, int_i[9] and int_i[2] rise in the same cycle -> irq_id_o=2; ack + EOI -> next request irq_id_o=9.
- Level source: EDGE=0, MASK=16'h0001, int_i[0] held 1 -> request id 0; ack, EOI with the line still high -> re-request id 0; drop the line in REQ -> withdrawal, irq_o=0, FSM IDLE.
- Simultaneous set/clear: W1C PEND bit 3 in the same cycle as a new int_i[3] edge reaching the detector -> PEND[3] remains 1.
- Mid-request reset: rst=0 while irq_o=1 in REQ -> irq_o=0 asynchronously; PEND=0 after release.

Source files
------------

// File: rtl/rv_int_ctrl.sv
// rtl/rv_int_ctrl.sv - 16-line interrupt controller with mask, edge/level detect, priority and req/ack/EOI FSM
// Optional macro RV_INT_CTRL_SYNC_EN inserts a two-flop synchronizer on int_i.
module rv_int_ctrl #(
    parameter int NUM_SRC = 16,
    parameter int ID_W    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     int_i,
    input  logic            we_i,
    input  logic [3:0]      addr_i,
    input  logic [31:0]     data_i,
    output logic [31:0]     data_o,
    output logic            irq_o,
    output logic [ID_W-1:0] irq_id_o,
    input  logic            irq_ack_i
);
    localparam logic [15:0] SRC_MASK = 16'((32'h1 << NUM_SRC) - 32'h1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_BUSY = 2'd2;

    logic [15:0]     s2;
    logic [15:0]     mask_q, mask_d;
    logic [15:0]     edge_q, edge_d;
    logic [15:0]     pend_q, pend_d;
    logic [15:0]     prev_q, prev_d;
    logic [1:0]      state_q, state_d;
    logic [ID_W-1:0] id_q, id_d;

    logic [15:0]     rise;
    logic [15:0]     pend_vis;
    logic [15:0]     req_vec;
    logic [15:0]     clr;
    logic [ID_W-1:0] low_id;
    logic            wr_mask, wr_edge, wr_pend, wr_eoi;
    logic            ack_take;
    logic            unused_bits;

    assign unused_bits = ^{data_i[31:16], addr_i[1:0]};

`ifdef RV_INT_CTRL_SYNC_EN
    logic [15:0] s1_q, s2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= int_i;
            s2_q <= s1_q;
        end
    end

    assign s2 = s2_q;
`else
    // Lines are already synchronous; hold them at 0 during reset like the flops would be.
    assign s2 = int_i & {16{rst}};
`endif

    assign wr_mask = we_i && (addr_i[3:2] == 2'd0);
    assign wr_edge = we_i && (addr_i[3:2] == 2'd1);
    assign wr_pend = we_i && (addr_i[3:2] == 2'd2);
    assign wr_eoi  = we_i && (addr_i[3:2] == 2'd3);

    assign rise     = s2 & ~prev_q & SRC_MASK;
    assign pend_vis = ((edge_q & pend_q) | (~edge_q & s2)) & SRC_MASK;
    assign req_vec  = pend_vis & mask_q;
    assign ack_take = (state_q == ST_REQ) && irq_ack_i;

    // A new edge in the same cycle as a W1C or ack clear keeps the bit set.
    assign clr    = (wr_pend ? data_i[15:0] : 16'h0) | (ack_take ? (16'h1 << id_q) : 16'h0);
    assign pend_d = edge_q & SRC_MASK & (rise | (pend_q & ~clr));
    assign mask_d = wr_mask ? (data_i[15:0] & SRC_MASK) : mask_q;
    assign edge_d = wr_edge ? (data_i[15:0] & SRC_MASK) : edge_q;
    assign prev_d = s2;

    always_comb begin
        low_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                low_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (req_vec != 16'h0) begin
                    id_d    = low_id;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (irq_ack_i) begin
                    state_d = ST_BUSY;
                end else if (!req_vec[id_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (wr_eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q  <= '0;
            edge_q  <= '0;
            pend_q  <= '0;
            prev_q  <= '0;
            state_q <= ST_IDLE;
            id_q    <= '0;
        end else begin
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            pend_q  <= pend_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    assign irq_o    = (state_q == ST_REQ);
    assign irq_id_o = id_q;

    always_comb begin
        data_o = 32'h0;
        case (addr_i[3:2])
            2'd0:    data_o = {16'h0, mask_q};
            2'd1:    data_o = {16'h0, edge_q};
            2'd2:    data_o = {16'h0, pend_vis};
            default: data_o = 32'({(state_q == ST_BUSY), id_q});
        endcase
    end

endmodule

// File: tb/tb_rv_int_ctrl.sv
// tb/tb_rv_int_ctrl.sv - self-checking bench for rv_int_ctrl (either RV_INT_CTRL_SYNC_EN build)
module tb_rv_int_ctrl;
`ifdef RV_INT_CTRL_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] int_i = '0;
    logic        we_i = 1'b0;
    logic [3:0]  addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        irq_o;
    logic [3:0]  irq_id_o;
    logic        irq_ack_i = 1'b0;

    int checks = 0;
    int failures = 0;

    rv_int_ctrl dut (
        .clk(clk), .rst(rst), .int_i(int_i), .we_i(we_i), .addr_i(addr_i),
        .data_i(data_i), .data_o(data_o), .irq_o(irq_o), .irq_id_o(irq_id_o),
        .irq_ack_i(irq_ack_i)
    );

    always #5 clk = ~clk;

    // Reference model: registers, a history of sampled lines, and the three-phase handshake.
    logic [15:0] m_mask, m_edge, m_pend, m_prev;
    logic [15:0] m_hist[$];
    int          m_state;
    int          m_id;

    function automatic void m_reset();
        m_mask = '0; m_edge = '0; m_pend = '0; m_prev = '0;
        m_hist.delete();
        m_state = 0; m_id = 0;
    endfunction

    function automatic logic [15:0] m_s2(input logic [15:0] iv);
        if (L == 0) return iv;
        if (m_hist.size() >= 2) return m_hist[m_hist.size() - 2];
        return 16'h0;
    endfunction

    function automatic logic [15:0] m_vis(input logic [15:0] iv);
        return (m_edge & m_pend) | (~m_edge & m_s2(iv));
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a, input logic [15:0] iv);
        case (a[3:2])
            2'd0:    return {16'h0, m_mask};
            2'd1:    return {16'h0, m_edge};
            2'd2:    return {16'h0, m_vis(iv)};
            default: return {27'h0, (m_state == 2), 4'(m_id)};
        endcase
    endfunction

    function automatic void m_step(input logic [15:0] iv, input logic we, input logic [3:0] a,
                                   input logic [31:0] d, input logic ack);
        logic [15:0] s2, rise, req, clr;
        int nstate, nid;
        s2 = m_s2(iv);
        rise = s2 & ~m_prev;
        req = m_vis(iv) & m_mask;
        clr = (we && a[3:2] == 2'd2) ? d[15:0] : 16'h0;
        nstate = m_state; nid = m_id;
        if (m_state == 0) begin
            if (req != 0) begin
                for (int i = 15; i >= 0; i--) if (req[i]) nid = i;
                nstate = 1;
            end
        end else if (m_state == 1) begin
            if (ack) begin
                clr[m_id] = 1'b1;
                nstate = 2;
            end else if (!req[m_id]) begin
                nstate = 0;
            end
        end else if (we && a[3:2] == 2'd3) begin
            nstate = 0;
        end
        m_pend = m_edge & (rise | (m_pend & ~clr));
        if (we && a[3:2] == 2'd0) m_mask = d[15:0];
        if (we && a[3:2] == 2'd1) m_edge = d[15:0];
        m_prev = s2;
        m_hist.push_back(iv);
        if (m_hist.size() > 3) void'(m_hist.pop_front());
        m_state = nstate; m_id = nid;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [15:0] iv, input logic we, input logic [3:0] a,
                       input logic [31:0] d, input logic ack);
        int_i = iv; we_i = we; addr_i = a; data_i = d; irq_ack_i = ack;
        @(posedge clk);
        if (!rst) m_reset();
        else m_step(iv, we, a, d, ack);
        @(negedge clk);
        we_i = 1'b0; irq_ack_i = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cyc(int_i, 1'b1, a, d, 1'b0);
    endtask

    task automatic idle(input logic [15:0] iv, input int n);
        for (int k = 0; k < n; k++) cyc(iv, 1'b0, addr_i, 32'h0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        addr_i = a;
        #1;
        v = data_o;
    endtask

    typedef struct {
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  raddr;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[8];

    logic [31:0] rv;
    logic [15:0] r_iv;
    logic        r_we, r_ack;
    logic [3:0]  r_a, r_ra;
    logic [31:0] r_d;
    int          sel;

    initial begin
        tbl[0] = '{4'h0, 32'hFFFF_1234, 4'h0, 32'h0000_1234};
        tbl[1] = '{4'h4, 32'hABCD_5678, 4'h4, 32'h0000_5678};
        tbl[2] = '{4'h8, 32'hFFFF_FFFF, 4'h0, 32'h0000_1234};
        tbl[3] = '{4'hC, 32'h0000_0000, 4'hC, 32'h0000_0000};
        tbl[4] = '{4'h0, 32'h0000_0000, 4'h8, 32'h0000_0000};
        tbl[5] = '{4'h4, 32'h0000_0000, 4'h4, 32'h0000_0000};
        tbl[6] = '{4'h0, 32'h0000_8001, 4'h0, 32'h0000_8001};
        tbl[7] = '{4'h0, 32'h0000_0000, 4'h0, 32'h0000_0000};
        m_reset();
        repeat (2) @(negedge clk);

        // Reset with every line high
        rst = 1'b0;
        idle(16'hFFFF, 3);
        check("rst_irq", irq_o, 0);
        rd(4'h0, rv); check("rst_mask", rv, 0);
        rd(4'h4, rv); check("rst_edge", rv, 0);
        rd(4'h8, rv); check("rst_pend", rv, 0);
        rd(4'hC, rv); check("rst_stat", rv, 0);
        rst = 1'b1;
        idle(16'hFFFF, L + 3);
        check("rel_irq", irq_o, 0);
        idle(16'h0, L + 2);

        for (int i = 0; i < 8; i++) begin
            wr(tbl[i].waddr, tbl[i].wdata);
            rd(tbl[i].raddr, rv);
            check($sformatf("tbl%0d", i), rv, tbl[i].exp);
        end

        // Edge source: one-cycle pulse on line 4
        wr(4'h0, 32'h10); wr(4'h4, 32'h10);
        for (int k = 1; k <= L + 2; k++) begin
            cyc((k == 1) ? 16'h10 : 16'h0, 1'b0, 4'h8, 32'h0, 1'b0);
            if (k == L + 1) begin
                rd(4'h8, rv); check("edge_pend", rv, 32'h10);
                check("edge_irq_early", irq_o, 0);
            end
        end
        check("edge_irq", irq_o, 1);
        check("edge_id", irq_id_o, 4);
        cyc(16'h0, 1'b0, 4'h8, 32'h0, 1'b1);
        check("edge_ack_irq", irq_o, 0);
        rd(4'h8, rv); check("edge_ack_pend", rv, 0);
        rd(4'hC, rv); check("edge_stat_busy", rv, 32'h14);
        wr(4'hC, 32'h0);
        rd(4'hC, rv); check("edge_stat_eoi", rv, 32'h04);

        // Priority: lines 9 and 2 rise together
        wr(4'h0, 32'hFFFF); wr(4'h4, 32'hFFFF);
        idle(16'h0204, L + 2);
        check("prio_irq", irq_o, 1);
        check("prio_id2", irq_id_o, 2);
        cyc(16'h0204, 1'b0, 4'h8, 32'h0, 1'b1);
        rd(4'h8, rv); check("prio_pend", rv, 32'h200);
        cyc(16'h0204, 1'b1, 4'hC, 32'h0, 1'b0);
        check("prio_gap", irq_o, 0);
        idle(16'h0204, 1);
        check("prio_irq9", irq_o, 1);
        check("prio_id9", irq_id_o, 9);
        cyc(16'h0204, 1'b0, 4'h8, 32'h0, 1'b1);
        cyc(16'h0, 1'b1, 4'hC, 32'h0, 1'b0);
        idle(16'h0, L + 2);

        // Level source on line 0
        wr(4'h4, 32'h0); wr(4'h0, 32'h1);
        idle(16'h1, L + 2);
        check("lvl_irq", irq_o, 1);
        check("lvl_id", irq_id_o, 0);
        cyc(16'h1, 1'b0, 4'h8, 32'h0, 1'b1);
        rd(4'hC, rv); check("lvl_busy", rv, 32'h10);
        cyc(16'h1, 1'b1, 4'hC, 32'h0, 1'b0);
        check("lvl_eoi_irq", irq_o, 0);
        idle(16'h1, 1);
        check("lvl_rereq", irq_o, 1);
        idle(16'h0, L + 1);
        check("lvl_withdraw", irq_o, 0);
        rd(4'hC, rv); check("lvl_idle_stat", rv, 32'h0);

        // W1C landing on the same edge as a new detection on line 3
        wr(4'h0, 32'h0); wr(4'h4, 32'h8);
        for (int c = 1; c <= L + 3; c++) begin
            cyc((c == 1 || c == 3) ? 16'h8 : 16'h0, (c == L + 3), 4'h8, 32'h8, 1'b0);
            if (c == L + 1) begin
                rd(4'h8, rv); check("sc_first", rv, 32'h8);
            end
        end
        rd(4'h8, rv); check("sc_set_wins", rv, 32'h8);
        cyc(16'h0, 1'b1, 4'h8, 32'h8, 1'b0);
        rd(4'h8, rv); check("sc_w1c", rv, 32'h0);

        // Reset while a request is outstanding
        wr(4'h0, 32'h20); wr(4'h4, 32'h20);
        cyc(16'h20, 1'b0, 4'h8, 32'h0, 1'b0);
        idle(16'h0, L + 1);
        check("mr_irq", irq_o, 1);
        rst = 1'b0;
        #1;
        check("mr_async", irq_o, 0);
        m_reset();
        idle(16'h0, 2);
        rst = 1'b1;
        idle(16'h0, 1);
        rd(4'h8, rv); check("mr_pend", rv, 0);
        rd(4'h0, rv); check("mr_mask", rv, 0);

        // Random traffic against the model
        wr(4'h4, 32'($urandom));
        wr(4'h0, 32'($urandom));
        for (int n = 0; n < 600; n++) begin
            r_iv = int_i ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            r_we = ($urandom % 6) == 0;
            sel = int'($urandom % 3);
            r_a = (sel == 0) ? 4'h0 : (sel == 1) ? 4'h8 : 4'hC;
            r_d = $urandom;
            r_ack = ($urandom % 3) == 0;
            r_ra = {2'($urandom_range(0, 3)), 2'b00};
            int_i = r_iv;
            rd(r_ra, rv);
            check($sformatf("rnd%0d_rd%h", n, r_ra), rv, m_read(r_ra, r_iv));
            cyc(r_iv, r_we, r_a, r_d, r_ack);
            check($sformatf("rnd%0d_irq", n), irq_o, (m_state == 1));
            if (m_state == 1) check($sformatf("rnd%0d_id", n), irq_id_o, m_id);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
